// File: rtl/spi_wrapper_pkg.sv
// spi_wrapper_pkg: shared types and constants for the SPI slave + RAM peripheral.
//   state_e   : slave FSM state encoding
//   CMD_*     : frame command codes carried in rx_data[9:8]
//   FRAME_W   : bits shifted in per frame; DATA_W : RAM word width
package spi_wrapper_pkg;

  localparam int unsigned FRAME_W = 10;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TXC_W   = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    CHK_CMD   = 3'b001,
    WRITE     = 3'b010,
    READ_ADD  = 3'b011,
    READ_DATA = 3'b100
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_ram.sv
// spi_ram: single-port byte RAM decoding completed SPI frames.
// Ports:
//   clk, rst_n  : system clock, synchronous active-low reset
//   rx_valid    : one-cycle strobe, rx_data holds a complete frame
//   rx_data     : {cmd[1:0], payload[7:0]}
//   dout        : read data, valid while/after tx_valid
//   tx_valid    : one-cycle strobe after a read-data frame
// RAM contents are not reset; address and output registers are.
module spi_ram
  import spi_wrapper_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_valid,
  input  logic [FRAME_W-1:0] rx_data,
  output logic [DATA_W-1:0]  dout,
  output logic               tx_valid
);

  logic [DATA_W-1:0]    mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]    dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 mem_we_c;
  logic [1:0]           cmd_c;

  // Out-of-range addresses: writes dropped, reads return zero.
  function automatic logic addr_ok(input logic [ADDR_SIZE-1:0] a);
    return 32'(a) < 32'(MEM_DEPTH);
  endfunction

  assign cmd_c = rx_data[FRAME_W-1 -: 2];

  // Frame decode.
  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    dout_d     = dout_q;
    tx_valid_d = 1'b0;
    mem_we_c   = 1'b0;
    if (rx_valid) begin
      unique case (cmd_c)
        CMD_WR_ADDR: wr_addr_d = rx_data[ADDR_SIZE-1:0];
        CMD_WR_DATA: mem_we_c  = addr_ok(wr_addr_q);
        CMD_RD_ADDR: rd_addr_d = rx_data[ADDR_SIZE-1:0];
        CMD_RD_DATA: begin
          dout_d     = addr_ok(rd_addr_q) ? mem[rd_addr_q] : '0;
          tx_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Storage array, deliberately outside reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[wr_addr_q] <= rx_data[DATA_W-1:0];
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: rtl/spi_wrapper.sv
// spi_wrapper: SPI slave front-end (system-clock sampled, no SCK) on a byte RAM.
// Ports:
//   clk, rst_n : system clock, synchronous active-low reset
//   SS_n       : slave select, active low, frames one transaction
//   MOSI       : serial frame input, MSB first
//   MISO       : serial read data, MSB first, 0 when not transmitting
// Optional: define SPI_WRAPPER_SVA_EN to compile assertions and transition coverage.
module spi_wrapper
  import spi_wrapper_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rd_addr_flag_q, rd_addr_flag_d;
  logic [DATA_W-1:0]  tx_shift_q, tx_shift_d;
  logic [TXC_W-1:0]   tx_cnt_q, tx_cnt_d;
  logic               tx_active_q, tx_active_d;
  logic               miso_q, miso_d;
  logic [DATA_W-1:0]  dout;
  logic               tx_valid;

  spi_ram #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_valid (rx_valid_q),
    .rx_data  (rx_data_q),
    .dout     (dout),
    .tx_valid (tx_valid)
  );

  // Slave FSM: frame capture, read-address flag and MISO serialiser.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_flag_d = rd_addr_flag_q;
    tx_shift_d     = tx_shift_q;
    tx_cnt_d       = tx_cnt_q;
    tx_active_d    = tx_active_q;
    miso_d         = 1'b0;
    if (SS_n) begin
      state_d     = IDLE;
      bit_cnt_d   = '0;
      tx_active_d = 1'b0;
      tx_cnt_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = CHK_CMD;
          bit_cnt_d = '0;
        end
        CHK_CMD: begin
          bit_cnt_d = '0;
          if (!MOSI)               state_d = WRITE;
          else if (!rd_addr_flag_q) state_d = READ_ADD;
          else                     state_d = READ_DATA;
        end
        WRITE, READ_ADD, READ_DATA: begin
          // Extra MOSI bits after a full frame are ignored.
          if (bit_cnt_q < CNT_W'(FRAME_W)) begin
            rx_data_d = {rx_data_q[FRAME_W-2:0], MOSI};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD)  rd_addr_flag_d = 1'b1;
              if (state_q == READ_DATA) rd_addr_flag_d = 1'b0;
            end
          end
          if (state_q == READ_DATA) begin
            if (tx_active_q) begin
              if (tx_cnt_q != '0) begin
                miso_d     = tx_shift_q[DATA_W-1];
                tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                tx_cnt_d   = tx_cnt_q - TXC_W'(1);
              end else begin
                tx_active_d = 1'b0;
              end
            end else if (tx_valid) begin
              // First bit goes out on the same edge dout is captured.
              miso_d      = dout[DATA_W-1];
              tx_shift_d  = {dout[DATA_W-2:0], 1'b0};
              tx_cnt_d    = TXC_W'(DATA_W - 1);
              tx_active_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_flag_q <= 1'b0;
      tx_shift_q     <= '0;
      tx_cnt_q       <= '0;
      tx_active_q    <= 1'b0;
      miso_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_flag_q <= rd_addr_flag_d;
      tx_shift_q     <= tx_shift_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_active_q    <= tx_active_d;
      miso_q         <= miso_d;
    end
  end

  assign MISO = miso_q;

`ifdef SPI_WRAPPER_SVA_EN
  a_rx_valid_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    rx_valid_q |=> !rx_valid_q);
  a_tx_valid_src: assert property (@(posedge clk) disable iff (!rst_n)
    tx_valid |-> $past(rx_valid_q && (rx_data_q[FRAME_W-1 -: 2] == CMD_RD_DATA)));
  a_idle_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == IDLE && SS_n) |=> (state_q == IDLE));
  a_miso_idle: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == IDLE) |-> !MISO);

  c_idle_chk:  cover property (@(posedge clk) state_q == IDLE      ##1 state_q == CHK_CMD);
  c_chk_wr:    cover property (@(posedge clk) state_q == CHK_CMD   ##1 state_q == WRITE);
  c_chk_ra:    cover property (@(posedge clk) state_q == CHK_CMD   ##1 state_q == READ_ADD);
  c_chk_rd:    cover property (@(posedge clk) state_q == CHK_CMD   ##1 state_q == READ_DATA);
  c_chk_idle:  cover property (@(posedge clk) state_q == CHK_CMD   ##1 state_q == IDLE);
  c_wr_idle:   cover property (@(posedge clk) state_q == WRITE     ##1 state_q == IDLE);
  c_ra_idle:   cover property (@(posedge clk) state_q == READ_ADD  ##1 state_q == IDLE);
  c_rd_idle:   cover property (@(posedge clk) state_q == READ_DATA ##1 state_q == IDLE);
`else
  // Checks compiled out; behaviour unchanged.
`endif

endmodule

// File: tb/tb_spi_wrapper.sv
// tb_spi_wrapper: directed, table-driven bench for spi_wrapper.
// Frames are driven on the falling edge; MISO is sampled on the falling edge.
module tb_spi_wrapper;

  logic clk;
  logic rst_n;
  logic SS_n;
  logic MOSI;
  logic MISO;

  int n_tests;
  int n_fail;

  spi_wrapper #(
    .MEM_DEPTH (256),
    .ADDR_SIZE (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .SS_n  (SS_n),
    .MOSI  (MOSI),
    .MISO  (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst_before;
    logic       cmd;
    logic [9:0] payload;
    int         nbits;    // payload bits sent before SS_n rises (10 = full frame)
    int         tail;     // cycles SS_n stays low after the 10th payload bit
    logic       chk;      // compare captured MISO byte
    logic [7:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    SS_n  = 1'b1;
    MOSI  = 1'b0;
    repeat (cycles) @(negedge clk);
    check("miso_in_reset", 8'(MISO), 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives one frame; captures MISO after edges 14..21 into rx (MSB first).
  task automatic send_frame(input string name, input logic cmd, input logic [9:0] pl,
                            input int nbits, input int tail, output logic [7:0] rx);
    logic [9:0] p;
    p    = pl;
    rx   = 8'h00;
    SS_n = 1'b0;
    MOSI = 1'b0;
    @(negedge clk);                       // edge 1
    MOSI = cmd;
    @(negedge clk);                       // edge 2
    for (int i = 0; i < nbits; i++) begin
      MOSI = p[9 - i];
      @(negedge clk);                     // edges 3..12
    end
    MOSI = 1'b0;
    if (nbits == 10) begin
      for (int k = 0; k < tail; k++) begin
        @(negedge clk);                   // edge 13 + k
        if (k >= 1 && k <= 8) rx[8 - k] = MISO;
        if (k == 9) check({name, "_miso_after_byte"}, 8'(MISO), 8'h00);
      end
    end
    SS_n = 1'b1;
    @(negedge clk);
    check({name, "_miso_ss_high"}, 8'(MISO), 8'h00);
  endtask

  vec_t vecs[$];
  logic [7:0] got;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    SS_n    = 1'b1;
    MOSI    = 1'b0;

    // Power-on reset and quiet period.
    @(negedge clk);
    check("miso_first_reset_edge", 8'(MISO), 8'h00);
    do_reset(14);
    repeat (3) begin
      @(negedge clk);
      check("miso_after_release", 8'(MISO), 8'h00);
    end

    vecs.push_back('{"wr_addr_ff",   1'b0, 1'b0, 10'h0FF, 10, 2,  1'b0, 8'h00});
    vecs.push_back('{"wr_data_55",   1'b0, 1'b0, 10'h155, 10, 2,  1'b0, 8'h00});
    vecs.push_back('{"rd_addr_ff",   1'b1, 1'b1, 10'h2FF, 10, 10, 1'b1, 8'h00});
    vecs.push_back('{"rd_data_55",   1'b0, 1'b1, 10'h355, 10, 10, 1'b1, 8'h55});
    vecs.push_back('{"wr_addr_00",   1'b0, 1'b0, 10'h000, 10, 2,  1'b0, 8'h00});
    vecs.push_back('{"wr_data_a3",   1'b0, 1'b0, 10'h1A3, 10, 2,  1'b0, 8'h00});
    vecs.push_back('{"rd_addr_00",   1'b0, 1'b1, 10'h200, 10, 10, 1'b1, 8'h00});
    vecs.push_back('{"rd_data_a3",   1'b0, 1'b1, 10'h3A5, 10, 10, 1'b1, 8'hA3});
    vecs.push_back('{"abort_wr",     1'b0, 1'b0, 10'h100, 5,  0,  1'b0, 8'h00});
    vecs.push_back('{"rd_addr_00b",  1'b0, 1'b1, 10'h200, 10, 2,  1'b0, 8'h00});
    vecs.push_back('{"rd_after_abt", 1'b0, 1'b1, 10'h300, 10, 10, 1'b1, 8'hA3});
    vecs.push_back('{"rd_addr_ffb",  1'b0, 1'b1, 10'h2FF, 10, 2,  1'b0, 8'h00});
    vecs.push_back('{"rd_partial",   1'b0, 1'b1, 10'h3FF, 10, 4,  1'b1, 8'h40});
    vecs.push_back('{"rd_addr_00c",  1'b0, 1'b1, 10'h200, 10, 10, 1'b1, 8'h00});
    vecs.push_back('{"rd_after_prt", 1'b0, 1'b1, 10'h3FF, 10, 10, 1'b1, 8'hA3});
    vecs.push_back('{"rd_addr_ffc",  1'b0, 1'b1, 10'h2FF, 10, 2,  1'b0, 8'h00});
    vecs.push_back('{"rd_ff_again",  1'b0, 1'b1, 10'h300, 10, 12, 1'b1, 8'h55});

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset(3);
      send_frame(vecs[i].name, vecs[i].cmd, vecs[i].payload,
                 vecs[i].nbits, vecs[i].tail, got);
      if (vecs[i].chk) check(vecs[i].name, got, vecs[i].exp);
    end

    // Reset mid read-data transmission: MISO drops at once and stays low.
    send_frame("rd_addr_ff_r", 1'b1, 10'h2FF, 10, 2, got);
    SS_n = 1'b0;
    MOSI = 1'b0;
    @(negedge clk);
    MOSI = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      MOSI = (i < 2) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    MOSI = 1'b0;
    repeat (3) @(negedge clk);            // edges 13..15, byte 0x55 in flight
    rst_n = 1'b0;
    @(negedge clk);
    check("miso_mid_frame_reset", 8'(MISO), 8'h00);
    rst_n = 1'b1;
    SS_n  = 1'b1;
    @(negedge clk);
    // Flag cleared by reset: next cmd-1 frame must be an address frame.
    send_frame("rd_addr_00_r", 1'b1, 10'h200, 10, 10, got);
    check("rd_addr_00_r", got, 8'h00);
    send_frame("rd_data_00_r", 1'b1, 10'h300, 10, 10, got);
    check("rd_data_00_r", got, 8'hA3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
